// File: rtl/core_run_pkg.sv
// Shared types and constants for the core run controller.
// Contents: run-state enum, counter width, core index width.
// No logic; imported by core_run_ctrl and run_cycle_counter.
package core_run_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      RUN    = 2'd2,
      DONE   = 2'd3
   } run_state_e;

   // Width of the run-length and watchdog counters.
   localparam int CNT_W = 32;

   // Largest core count the index encoder is sized for.
   localparam int NCORES_MAX = 16;
   localparam int CORE_W     = $clog2(NCORES_MAX);

endpackage

// File: rtl/run_cycle_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Latency: count visible the cycle after the enabled edge; clear wins over enable.
// No backpressure: holds at all-ones instead of wrapping.
//
// Ports:
//   clk, rstn : clock, synchronous active-low reset
//   clr       : zero the counter at the next edge
//   inc       : add one at the next edge (ignored once saturated)
//   cnt       : current count
module run_cycle_counter
   import core_run_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/core_run_ctrl.sv
// Run controller: staggered enable of masked cores, per-core finish capture, watchdog abort.
// Latency: first enable one cycle after accepted start; done one cycle after the final finish.
// No backpressure: start is only sampled in IDLE and is dropped otherwise.
//
// Ports:
//   clk, rstn    : clock, synchronous active-low reset
//   start        : run request, core_mask captured when accepted
//   opend        : per-core end-of-program level flags
//   en           : per-core registered enable
//   busy, done   : run in progress / one-cycle completion pulse
//   timeout      : sticky watchdog abort flag
//   cycle_count  : saturating run length in busy edges
module core_run_ctrl
   import core_run_pkg::*;
#(
   parameter int NCORES   = 4,
   parameter int STAGGER  = 2,
   parameter int WATCHDOG = 65535
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic [NCORES-1:0] core_mask,
   input  logic [NCORES-1:0] opend,
   output logic [NCORES-1:0] en,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [CNT_W-1:0]  cycle_count
);

   run_state_e        state_q,    state_d;
   logic [NCORES-1:0] en_q,       en_d;
   logic [NCORES-1:0] mask_q,     mask_d;
   logic [NCORES-1:0] fin_q,      fin_d;
   logic [NCORES-1:0] launched_q, launched_d;
   logic [NCORES-1:0] armed_q,    armed_d;
   logic [CNT_W-1:0]  stg_q,      stg_d;
   logic              timeout_q,  timeout_d;

   logic [NCORES-1:0] pend;
   logic [NCORES-1:0] sel_oh;
   logic [CORE_W-1:0] sel_idx;
   logic              sel_vld;
   logic [NCORES-1:0] cap;
   logic              cnt_clr;
   logic              cnt_inc;
   logic              wd_hit;
   logic [CNT_W-1:0]  wd_cnt;

   // Lowest-index core still waiting for its enable. In IDLE the
   // candidate set is the incoming mask so the first core can be
   // enabled on the very edge that accepts start.
   always_comb begin
      pend    = (state_q == IDLE) ? core_mask : (mask_q & ~launched_q);
      sel_vld = 1'b0;
      sel_idx = '0;
      for (int i = NCORES - 1; i >= 0; i--) begin
         if (pend[i]) begin
            sel_vld = 1'b1;
            sel_idx = CORE_W'(i);
         end
      end
      sel_oh = '0;
      for (int i = 0; i < NCORES; i++) begin
         sel_oh[i] = sel_vld && (sel_idx == CORE_W'(i));
      end
   end

   // A core may finish only once its enable has been seen at an earlier
   // edge (armed), which masks an opend left high from a previous program.
   assign cap    = en_q & armed_q & opend & mask_q;
   assign wd_hit = (wd_cnt >= CNT_W'(WATCHDOG - 1));

   always_comb begin
      state_d    = state_q;
      en_d       = en_q;
      mask_d     = mask_q;
      fin_d      = fin_q;
      launched_d = launched_q;
      stg_d      = stg_q;
      timeout_d  = timeout_q;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               cnt_clr   = 1'b1;
               timeout_d = 1'b0;
               fin_d     = '0;
               stg_d     = '0;
               mask_d    = core_mask;
               if (core_mask != '0) begin
                  en_d       = sel_oh;
                  launched_d = sel_oh;
                  state_d    = (sel_oh == core_mask) ? RUN : LAUNCH;
               end else begin
                  launched_d = '0;
                  state_d    = DONE;
               end
            end
         end

         LAUNCH, RUN: begin
            cnt_inc = 1'b1;
            fin_d   = fin_q | cap;
            en_d    = en_q & ~cap;

            if (state_q == LAUNCH) begin
               if (stg_q == CNT_W'(STAGGER - 1)) begin
                  stg_d      = '0;
                  en_d       = en_d | sel_oh;
                  launched_d = launched_q | sel_oh;
                  if ((launched_q | sel_oh) == mask_q) begin
                     state_d = RUN;
                  end
               end else begin
                  stg_d = stg_q + CNT_W'(1);
               end
            end

            // A final finish on the watchdog edge counts as a clean end.
            if (fin_d == mask_q) begin
               state_d = DONE;
            end else if (wd_hit) begin
               en_d      = '0;
               timeout_d = 1'b1;
               state_d   = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Armed means the enable was already high at this edge and stays high.
      armed_d = en_q & en_d;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= IDLE;
         en_q       <= '0;
         mask_q     <= '0;
         fin_q      <= '0;
         launched_q <= '0;
         armed_q    <= '0;
         stg_q      <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         en_q       <= en_d;
         mask_q     <= mask_d;
         fin_q      <= fin_d;
         launched_q <= launched_d;
         armed_q    <= armed_d;
         stg_q      <= stg_d;
         timeout_q  <= timeout_d;
      end
   end

   run_cycle_counter #(.W(CNT_W)) u_cycle_cnt (
      .clk  (clk),
      .rstn (rstn),
      .clr  (cnt_clr),
      .inc  (cnt_inc),
      .cnt  (cycle_count)
   );

   run_cycle_counter #(.W(CNT_W)) u_wd_cnt (
      .clk  (clk),
      .rstn (rstn),
      .clr  (cnt_clr),
      .inc  (cnt_inc),
      .cnt  (wd_cnt)
   );

   assign en      = en_q;
   assign busy    = (state_q == LAUNCH) || (state_q == RUN);
   assign done    = (state_q == DONE);
   assign timeout = timeout_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: directed scenarios plus randomized runs, each run
// predicted from edge arithmetic (launch edge, finish edge, watchdog edge).
// Cycle numbering: cyc = index of the most recent rising edge.
module tb_core_run_ctrl;
   import core_run_pkg::*;

   localparam int NC  = 4;
   localparam int STG = 2;
   localparam int WD  = 50;

   logic             clk = 1'b0;
   logic             rstn;
   logic             start;
   logic [NC-1:0]    core_mask;
   logic [NC-1:0]    opend;
   logic [NC-1:0]    en;
   logic             busy;
   logic             done;
   logic             timeout;
   logic [CNT_W-1:0] cycle_count;

   core_run_ctrl #(.NCORES(NC), .STAGGER(STG), .WATCHDOG(WD)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .start       (start),
      .core_mask   (core_mask),
      .opend       (opend),
      .en          (en),
      .busy        (busy),
      .done        (done),
      .timeout     (timeout),
      .cycle_count (cycle_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int          hold_count = 0;
   logic        hold_to    = 1'b0;
   int          cur_t;
   int          cur_rel[4];
   logic [3:0]  cur_m;

   task automatic step();
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_en"},      32'(en),      32'(0));
      chk({tag, "_busy"},    32'(busy),    32'(0));
      chk({tag, "_done"},    32'(done),    32'(0));
      chk({tag, "_timeout"}, 32'(timeout), 32'(hold_to));
      chk({tag, "_count"},   cycle_count,  32'(hold_count));
   endtask

   // Masked cores follow their scheduled level; unmasked cores toggle at random.
   task automatic drive_opend();
      int e;
      e = cyc + 1;
      for (int i = 0; i < 4; i++) begin
         opend[i] = cur_m[i] ? (e >= cur_t + cur_rel[i]) : 1'($urandom_range(0, 1));
      end
   endtask

   task automatic idle_gap(input int n);
      start = 1'b0;
      for (int j = 0; j < n; j++) begin
         core_mask = 4'($urandom_range(0, 15));
         drive_opend();
         step();
         chk_idle("idle");
      end
   endtask

   // One run: start accepted at edge t. Core i's opend is high at every
   // edge >= t+rel_i. reset_at>0 pulls reset at edge t+reset_at.
   task automatic run_case(input logic [3:0] m, input int r0, input int r1,
                           input int r2, input int r3, input int reset_at);
      int         le[4];
      int         fe[4];
      int         fin;
      int         end_e;
      int         k;
      int         c;
      bit         abort;
      logic [3:0] exp_en;

      cur_rel[0] = r0; cur_rel[1] = r1; cur_rel[2] = r2; cur_rel[3] = r3;
      cur_m = m;
      cur_t = cyc + 1;
      k     = 0;
      fin   = cur_t;
      for (int i = 0; i < 4; i++) begin
         le[i] = 0;
         fe[i] = 0;
         if (m[i]) begin
            le[i] = cur_t + k * STG;
            k++;
            // earliest capture is two edges after the enabling edge
            fe[i] = (cur_t + cur_rel[i] > le[i] + 2) ? cur_t + cur_rel[i] : le[i] + 2;
            if (fe[i] > fin) fin = fe[i];
         end
      end
      abort = (fin > cur_t + WD);
      end_e = abort ? cur_t + WD : fin;

      start     = 1'b1;
      core_mask = m;
      drive_opend();

      while (cyc <= end_e) begin
         step();
         c = cyc;
         if (reset_at > 0 && c == cur_t + reset_at) begin
            hold_count = 0;
            hold_to    = 1'b0;
            chk_idle("reset");
            rstn  = 1'b1;
            start = 1'b0;
            return;
         end
         exp_en = '0;
         for (int i = 0; i < 4; i++) begin
            exp_en[i] = m[i] && (le[i] <= c) && (c < fe[i]) && (c < end_e);
         end
         chk("en",      32'(en),      32'(exp_en));
         chk("busy",    32'(busy),    32'(c < end_e));
         chk("done",    32'(done),    32'(c == end_e));
         chk("timeout", 32'(timeout), 32'(abort && (c >= end_e)));
         chk("count",   cycle_count,  32'(((c < end_e) ? c : end_e) - cur_t));

         if (reset_at > 0 && c == cur_t + reset_at - 1) rstn = 1'b0;
         // start pulses while busy or in DONE must be ignored
         start     = (c <= end_e) ? 1'($urandom_range(0, 1)) : 1'b0;
         core_mask = 4'($urandom_range(0, 15));
         drive_opend();
      end
      start      = 1'b0;
      hold_count = end_e - cur_t;
      hold_to    = abort;
   endtask

   initial begin
      rstn      = 1'b0;
      start     = 1'b0;
      core_mask = '0;
      opend     = '0;
      cur_m     = '0;
      cur_t     = 0;
      for (int i = 0; i < 4; i++) cur_rel[i] = 0;

      step();
      step();
      chk_idle("rst");
      rstn = 1'b1;
      step();
      chk_idle("post_rst");

      // all four cores, all end together
      run_case(4'b1111, 20, 20, 20, 20, 0);
      idle_gap(2);
      // two cores finishing far apart, unmasked opend toggling
      run_case(4'b0101, 10, 999, 30, 999, 0);
      idle_gap(1);
      // stale opend already high before start
      run_case(4'b0001, -5, -5, -5, -5, 0);
      idle_gap(1);
      // core 1 never ends: watchdog abort, timeout stays sticky in idle
      run_case(4'b0011, 5, 1000, 0, 0, 0);
      idle_gap(3);
      // zero mask: immediate done, clears timeout
      run_case(4'b0000, 0, 0, 0, 0, 0);
      idle_gap(1);
      // final finish exactly on the watchdog edge wins over the abort
      run_case(4'b1000, 0, 0, 0, WD, 0);
      idle_gap(1);
      // finish one edge after the watchdog edge loses
      run_case(4'b0010, 0, WD + 1, 0, 0, 0);
      idle_gap(1);
      // reset during RUN
      run_case(4'b1111, 1000, 1000, 1000, 1000, 15);
      idle_gap(2);

      for (int r = 0; r < 14; r++) begin
         int rv[4];
         for (int i = 0; i < 4; i++) begin
            rv[i] = ($urandom_range(0, 5) == 0) ? 500 : int'($urandom_range(0, 45)) - 5;
         end
         run_case(4'($urandom_range(0, 15)), rv[0], rv[1], rv[2], rv[3], 0);
         idle_gap(int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/core_run_ctrl.md
# core_run_ctrl

Run controller that drives the per-core enable vector `en[3:0]` of the quad-core processor top, which gates each core's clock and forces its memory/instruction requests idle. It accepts a start request with a core mask and enables the selected cores one at a time, STAGGER cycles apart, so their first instruction fetches do not collide. It then watches each core's `OPEND` end-of-program flag and disables each core as it finishes. When every selected core has finished, or the watchdog expires, it signals completion and reports the run length in cycles.

## Interface
- `NCORES`, 4: number of cores; width of the mask, opend and en vectors.
- `STAGGER`, 2: cycles between successive core enables; legal range ≥1.
- `WATCHDOG`, 65535: maximum busy cycles before a forced abort; legal range ≥1.

- `clk` in 1: single clock; every flop is on its rising edge.
- `rstn` in 1: reset, synchronous, active-low.
- `start` in 1: run request; sampled only in IDLE.
- `core_mask` in NCORES: cores to run; captured on an accepted `start`.
- `opend` in NCORES: per-core end-of-program level flag.
- `en` out NCORES: per-core enable; registered.
- `busy` out 1: high from the first cycle after an accepted start until done.
- `done` out 1: single-cycle completion pulse.
- `timeout` out 1: sticky watchdog-abort flag; cleared by the next accepted start.
- `cycle_count` out 32: run length; saturates at 0xFFFFFFFF; holds its value until the next accepted start.

## Operation
- Reset (`rstn`=0 at an edge): all outputs are 0, state is IDLE, and internal mask, finished and counters are cleared. Reset asserted mid-run takes effect at that edge; cores are disabled immediately.
- States:
  - IDLE → LAUNCH on `start`=1 with `core_mask`≠0. Captures the mask, clears `finished`, `cycle_count` and `timeout`.
  - IDLE → DONE on `start`=1 with `core_mask`=0. No core is enabled and `cycle_count` stays 0.
  - LAUNCH: sets `en` for the lowest-index masked core not yet launched, then the next one every STAGGER cycles. Goes to RUN once the last masked core is launched.
  - RUN: waits. Goes to DONE when `finished`==mask.
  - DONE: `done`=1 and `busy`=0 for one cycle, then IDLE.
- Finish capture: at any edge in LAUNCH or RUN, when `en[i]`=1, `opend[i]`=1, and `en[i]` has been 1 for at least one previous edge, the block sets `finished[i]` and clears `en[i]`. A stale `opend` is ignored on the first enabled edge and whenever `en[i]`=0.
- Finish capture also runs in LAUNCH. If every core launched so far has finished and all masked cores are launched, the block goes straight to DONE.
- `opend` of unmasked cores is ignored.
- `cycle_count`:
  - Increments on every edge while the state is LAUNCH or RUN, counting the edge at which the final finish is captured.
  - Saturates instead of wrapping.
- Watchdog:
  - A busy-cycle counter reaching WATCHDOG clears all `en`, sets `timeout`=1 and goes to DONE.
  - A final finish captured on that same edge wins: `timeout` stays 0.
- `start` while `busy` or in DONE is ignored; it is not queued.

## Timing
- Accepted `start` at edge t:
  - `busy`=1 and `en[first]`=1 from cycle t+1.
  - The k-th masked core (k from 0) is enabled from cycle t+1+k·STAGGER.
- Finish captured at edge e: `en[i]`=0 from cycle e+1.
- If edge e captures the final finish, `done`=1 in cycle e+1 and `busy`=0 in that cycle.
- Zero-mask start at edge t: `done`=1 in cycle t+1. `busy` never rises.
- The earliest a new `start` is accepted is the cycle after `done`.

## Structure
- Package `core_run_pkg`:
  - State enum {IDLE, LAUNCH, RUN, DONE}.
  - `CNT_W`=32.
  - `CORE_W` localparam for the core index width.
- Sub-module `run_cycle_counter`: 32-bit saturating counter with synchronous clear and enable. One instance serves `cycle_count`; the watchdog counter is a second instance.
- Lowest-unlaunched-core selection is a combinational priority encoder inside the main module.

## Test plan
- Mask 4'b1111, STAGGER=2, start at edge 10:
  - `en` goes 0001@11, 0011@13, 0111@15, 1111@17.
  - `opend` all high at 30: `en`=0@31, `done`=1@31, `cycle_count`=20.
- Mask 4'b0101, core 0 `opend` at 20, core 2 `opend` at 40:
  - `en[0]` drops @21.
  - `done`@41, `cycle_count`=30 (start at 10).
  - `en[1]` and `en[3]` never rise, even with `opend[3]` toggling.
- Stale `opend`=4'b1111 held high before start, mask 4'b0001, STAGGER=1, start at edge 5:
  - `en[0]`=1@6, captured at edge 7, `done`@8, `cycle_count`=2.
- WATCHDOG=50, mask 4'b0011, core 1 never ends:
  - At the 50th busy edge `en`=0, `timeout`=1 and a `done` pulse follows.
  - The next start clears `timeout`.
- Zero mask at edge 3: `done`@4, `busy` stays 0, `cycle_count`=0.
- Reset mid-run and start-while-busy:
  - `rstn`=0 at edge 25 during RUN: all outputs 0@26.
  - `start` pulses during RUN are ignored: mask and count are unchanged.
